mcycle_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit for the ARM processor datapath (MUL/DIV path).

---
 rtl/mcycle_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mcycle_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_unit.sv
// Iterative multi-cycle multiply/divide unit: shift-add multiply and restoring divide, signed or unsigned.
// Optional MCYCLE_EARLY_TERM_EN: multiplies stop as soon as the remaining multiplier magnitude is zero.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;          // product / quotient needs negation
  logic               rem_neg_q, rem_neg_d;  // remainder follows dividend sign
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Launch-side decode and operand magnitudes
  logic             signed_op;
  logic             launch_div;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign signed_op  = ~MCycleOp[0];
  assign launch_div = MCycleOp[1];
  assign mag1       = (signed_op && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
  assign mag2       = (signed_op && Operand2[WIDTH-1]) ? -Operand2 : Operand2;

  // Restoring-divide step: acc holds {remainder, dividend/quotient}; divisor sits in mcand low half.
  logic [WIDTH:0]     sh_rem;
  logic [WIDTH:0]     trial;
  logic               fits;
  logic [2*WIDTH-1:0] div_step;

  assign sh_rem   = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial    = sh_rem - {1'b0, mcand_q[WIDTH-1:0]};
  assign fits     = ~trial[WIDTH];
  assign div_step = fits ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                         : {sh_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign-corrected final values, consumed in FINISH
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;

  assign prod_fin = neg_q     ? -acc_q                  : acc_q;
  assign quo_fin  = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
  assign rem_fin  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    op1_d     = op1_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    res1_d    = res1_q;
    res2_d    = res2_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          is_div_d  = launch_div;
          neg_d     = signed_op && (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
          rem_neg_d = signed_op && Operand1[WIDTH-1];
          div0_d    = launch_div && (Operand2 == '0);
          op1_d     = Operand1;
          dbz_d     = 1'b0;
          cnt_d     = CW'(WIDTH - 1);
          state_d   = COMPUTE;
          if (launch_div) begin
            acc_d    = {{WIDTH{1'b0}}, mag1};
            mcand_d  = {{WIDTH{1'b0}}, mag2};
            mplier_d = '0;
            if (Operand2 == '0) begin
              state_d = FINISH;
              cnt_d   = '0;
            end
          end else begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag1};
            mplier_d = mag2;
`ifdef MCYCLE_EARLY_TERM_EN
            if (mag2 == '0) begin
              state_d = FINISH;
              cnt_d   = '0;
            end
`endif
          end
        end
      end

      COMPUTE: begin
        if (is_div_q) begin
          acc_d = div_step;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end

        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end

`ifdef MCYCLE_EARLY_TERM_EN
        // Remaining multiplier bits are all zero after this step: product is complete.
        if (!is_div_q && (mplier_q[WIDTH-1:1] == '0)) begin
          state_d = FINISH;
          cnt_d   = '0;
        end
`endif
      end

      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div0_q) begin
          res1_d = '1;
          res2_d = op1_q;
          dbz_d  = 1'b1;
        end else if (is_div_q) begin
          res1_d = quo_fin;
          res2_d = rem_fin;
        end else begin
          res1_d = prod_fin[WIDTH-1:0];
          res2_d = prod_fin[2*WIDTH-1:WIDTH];
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      op1_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      op1_q     <= op1_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      res1_q    <= res1_d;
      res2_q    <= res2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Result1   = res1_q;
  assign Result2   = res2_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit at WIDTH=4: expected results queued at launch, compared on Done.
module tb_mcycle_unit;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   MCycleOp = '0;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;
  logic         Done;
  logic         DivByZero;

  always #5 CLK = ~CLK;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Start     (Start),
    .MCycleOp  (MCycleOp),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .Result1   (Result1),
    .Result2   (Result2),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic         dbz;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           done_cnt = 0;
  logic [W-1:0] last_r1 = '0;
  logic [W-1:0] last_r2 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa, sbv, p, q, r;
    sa    = op[0] ? int'(a) : int'($signed(a));
    sbv   = op[0] ? int'(b) : int'($signed(b));
    e.dbz = 1'b0;
    if (!op[1]) begin
      p    = sa * sbv;
      e.r1 = p[W-1:0];
      e.r2 = p[2*W-1:W];
    end else if (b == '0) begin
      e.r1  = '1;
      e.r2  = a;
      e.dbz = 1'b1;
    end else begin
      q    = sa / sbv;
      r    = sa % sbv;
      e.r1 = q[W-1:0];
      e.r2 = r[W-1:0];
    end
    return e;
  endfunction

  // Drive-negedge to Done-negedge distance
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
    int lat;
    lat = W + 2;
    if (op[1] && b == '0) lat = 2;
`ifdef MCYCLE_EARLY_TERM_EN
    if (!op[1]) begin
      logic [W-1:0] mag;
      mag = (!op[0] && b[W-1]) ? -b : b;
      lat = 2;
      for (int i = 0; i < W; i++) if (mag[i]) lat = i + 3;
    end
`endif
    return lat;
  endfunction

  always @(negedge CLK) begin
    if (!RESET && Done) begin
      done_cnt++;
      check("busy_low_at_done", Busy, 0);
      if (sb.size() == 0) begin
        check("scoreboard_nonempty_at_done", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result1", Result1, e.r1);
        check("result2", Result2, e.r2);
        check("divbyzero", DivByZero, e.dbz);
        last_r1 = e.r1;
        last_r2 = e.r2;
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, busy_n, d0, el;
    el = exp_lat(op, b);
    @(negedge CLK);
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    sb.push_back(model(op, a, b));
    d0     = done_cnt;
    busy_n = 0;
    @(negedge CLK);
    Start    = 1'b0;
    MCycleOp = 2'($urandom);
    Operand1 = W'($urandom);
    Operand2 = W'($urandom);
    lat = 1;
    if (Busy) busy_n++;
    check("dbz_clear_at_launch", DivByZero, 0);
    check("hold_r1_at_launch", Result1, last_r1);
    check("hold_r2_at_launch", Result2, last_r2);
    while (!Done && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (Busy) busy_n++;
    end
    check("latency", lat, el);
    check("busy_cycles", busy_n, el - 1);
    @(negedge CLK);
    check("done_once", done_cnt - d0, 1);
    check("done_pulse_low", Done, 0);
  endtask

  task automatic back_to_back();
    logic [1:0]   ops[3];
    logic [W-1:0] as[3];
    logic [W-1:0] bs[3];
    int           gap;
    ops = '{2'b11, 2'b10, 2'b11};
    as  = '{4'b1110, 4'b1001, 4'b0111};
    bs  = '{4'b0011, 4'b0011, 4'b0010};
    @(negedge CLK);
    MCycleOp = ops[0];
    Operand1 = as[0];
    Operand2 = bs[0];
    Start    = 1'b1;
    sb.push_back(model(ops[0], as[0], bs[0]));
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      check("b2b_busy_after_launch", Busy, 1);
      if (i < 3) begin
        MCycleOp = ops[i];
        Operand1 = as[i];
        Operand2 = bs[i];
        sb.push_back(model(ops[i], as[i], bs[i]));
      end else begin
        Start    = 1'b0;
        Operand1 = W'($urandom);
        Operand2 = W'($urandom);
      end
      gap = 1;
      while (!Done && gap < 40) begin
        @(negedge CLK);
        gap++;
      end
      check("b2b_launch_to_done", gap, W + 2);
    end
    @(negedge CLK);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge CLK);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_r1", Result1, 0);
    check("reset_r2", Result2, 0);
    check("reset_dbz", DivByZero, 0);
    RESET = 1'b0;

    run_op(2'b00, 4'b1111, 4'b1111);
    run_op(2'b00, 4'b1101, 4'b0010);
    run_op(2'b01, 4'b0010, 4'b0110);
    run_op(2'b10, 4'b1001, 4'b0010);
    run_op(2'b10, 4'b1010, 4'b1100);
    run_op(2'b11, 4'b1000, 4'b0100);
    run_op(2'b11, 4'b1001, 4'b0000);
    repeat (3) @(negedge CLK);
    check("dbz_held", DivByZero, 1);
    run_op(2'b10, 4'b1000, 4'b1111);
    run_op(2'b01, 4'b0000, 4'b0101);
    run_op(2'b00, 4'b0111, 4'b0000);
    run_op(2'b00, 4'b1000, 4'b1000);
    run_op(2'b10, 4'b0000, 4'b0011);
    run_op(2'b11, 4'b0011, 4'b1001);
    run_op(2'b10, 4'b0011, 4'b0000);
    run_op(2'b01, 4'b1111, 4'b1111);
    for (int i = 0; i < 12; i++) run_op(2'($urandom), W'($urandom), W'($urandom));

    back_to_back();

    // Abort a divide in flight with an asynchronous reset pulse
    @(negedge CLK);
    MCycleOp = 2'b11;
    Operand1 = 4'b1000;
    Operand2 = 4'b0100;
    Start    = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (2) @(negedge CLK);
    check("busy_before_reset", Busy, 1);
    #1 RESET = 1'b1;
    #1;
    check("midreset_busy", Busy, 0);
    check("midreset_done", Done, 0);
    check("midreset_r1", Result1, 0);
    check("midreset_r2", Result2, 0);
    @(negedge CLK);
    RESET   = 1'b0;
    last_r1 = '0;
    last_r2 = '0;
    d0      = done_cnt;
    repeat (12) @(negedge CLK);
    check("no_done_after_reset", done_cnt - d0, 0);
    check("idle_after_reset", Busy, 0);
    run_op(2'b11, 4'b1000, 4'b0100);
    run_op(2'b01, 4'b0010, 4'b0110);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
